// File: rtl/pc_if.sv
// pc_if: request and response bundle between fetch control and pc_unit
interface pc_if #(parameter int ADDR_W = 32);
  logic stall, br_taken, jmp, jmp_link, jr, jr_ret, exc_req;
  logic [15:0] br_off;
  logic [25:0] jmp_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] pc, pc_plus4, epc, badaddr, ras_top;
  logic exc_taken, ras_empty, ras_uflow;
  modport master (
    output stall, br_taken, br_off, jmp, jmp_link, jmp_tgt, jr, jr_ret, jr_tgt, exc_req,
    input  pc, pc_plus4, epc, badaddr, exc_taken, ras_top, ras_empty, ras_uflow
  );
  modport slave (
    input  stall, br_taken, br_off, jmp, jmp_link, jmp_tgt, jr, jr_ret, jr_tgt, exc_req,
    output pc, pc_plus4, epc, badaddr, exc_taken, ras_top, ras_empty, ras_uflow
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC priority select, exception redirect and return-address stack
module pc_unit #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          RAS_DEPTH    = 4
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, bad_q, pc_plus4, br_tgt, jmp_tgt;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic exc_q, uflow_q, live, jr_bad, exc, pop_req, pop, push, uflow;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_tgt   = pc_plus4 + {{(ADDR_W-18){bus.br_off[15]}}, bus.br_off, 2'b00};
  assign jmp_tgt  = {pc_plus4[ADDR_W-1:28], bus.jmp_tgt, 2'b00};
  // live: a decode/execute request may act this cycle (no exception, no stall)
  assign live    = !bus.exc_req && !bus.stall;
  assign jr_bad  = live && bus.jr && |bus.jr_tgt[1:0];
  assign exc     = bus.exc_req || jr_bad;
  assign pop_req = live && bus.jr && !jr_bad && bus.jr_ret;
  assign pop     = pop_req && cnt_q != '0;
  assign uflow   = pop_req && cnt_q == '0;
  assign push    = live && !bus.jr && bus.jmp && bus.jmp_link;
  always_comb begin
    pc_d  = exc ? ADDR_W'(EXC_VECTOR) : bus.stall ? pc_q : bus.jr ? bus.jr_tgt :
            bus.jmp ? jmp_tgt : bus.br_taken ? br_tgt : pc_plus4;
    top_d = push ? top_q + PW'(1) : pop ? top_q - PW'(1) : top_q;
    cnt_d = push ? (cnt_q == CW'(RAS_DEPTH) ? cnt_q : cnt_q + CW'(1)) : pop ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= ADDR_W'(RESET_VECTOR);
      epc_q   <= '0;
      bad_q   <= '0;
      exc_q   <= 1'b0;
      uflow_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      exc_q   <= exc;
      uflow_q <= uflow;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      if (exc) epc_q <= pc_q;
      if (jr_bad) bad_q <= bus.jr_tgt;
      if (push) ras_q[top_d] <= pc_plus4;
    end
  end
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.epc       = epc_q;
  assign bus.badaddr   = bad_q;
  assign bus.exc_taken = exc_q;
  assign bus.ras_empty = cnt_q == '0;
  assign bus.ras_top   = cnt_q == '0 ? '0 : ras_q[top_q];
  assign bus.ras_uflow = uflow_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit. Next generation of the bare PC register: one register, plus next-PC selection, a stall hold, exception redirect with EPC capture, jump-register alignment checking, and a small return-address stack (RAS).
- Sits at the front of the fetch stage. It drives the instruction-memory address and takes redirect requests from decode and execute.

Parameters:
- ADDR_W, 32, PC width in bits; must be ≥ 29.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; truncated to ADDR_W.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on any exception.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold the PC; ignores jump, branch and jr requests
- br_taken  in  1  take a conditional branch this cycle
- br_off  in  16  signed word offset of the branch
- jmp  in  1  absolute jump (j or jal)
- jmp_link  in  1  with jmp: jal, push the return address onto the RAS
- jmp_tgt  in  26  jump target field
- jr  in  1  jump to a register value
- jr_ret  in  1  with jr: return, pop the RAS
- jr_tgt  in  ADDR_W  register target
- exc_req  in  1  external exception request
- pc  out  ADDR_W  current PC (fetch address)
- pc_plus4  out  ADDR_W  pc + 4, combinational
- epc  out  ADDR_W  PC captured on the last exception
- badaddr  out  ADDR_W  last misaligned jr target
- exc_taken  out  1  one-cycle pulse when an exception redirect occurs
- ras_top  out  ADDR_W  predicted return address (top entry); 0 when empty
- ras_empty  out  1  RAS holds no entries
- ras_uflow  out  1  one-cycle pulse on a pop while empty

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset values: pc = RESET_VECTOR; epc = 0; badaddr = 0; exc_taken = 0; ras_uflow = 0; RAS count = 0, so ras_empty = 1 and ras_top = 0.
- Reset mid-operation discards any pending request and clears the RAS.
- Arithmetic: all additions are modulo 2^ADDR_W and wrap silently.
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + (sign_extend(br_off) << 2).
  - Jump target = {pc_plus4[ADDR_W-1:28], jmp_tgt, 2'b00}.
- Next PC, highest priority first, evaluated once per clock edge:
  1. rst → RESET_VECTOR.
  2. exc_req → EXC_VECTOR; epc <= pc. Overrides stall.
  3. stall → pc holds. jmp, br_taken and jr are ignored, with no RAS update and no alignment check.
  4. jr with jr_tgt[1:0] != 0 → exception: pc <= EXC_VECTOR, epc <= pc, badaddr <= jr_tgt. No RAS pop.
  5. jr → pc <= jr_tgt. If jr_ret is set, pop the RAS.
  6. jmp → pc <= jump target. If jmp_link is set, push pc_plus4.
  7. br_taken → pc <= branch target.
  8. Otherwise → pc <= pc_plus4.
- Lower-priority requests asserted in the same cycle are dropped. The requester must hold or reissue them.
- exc_taken is registered. It is 1 in the cycle after any exception load (case 2 or 4), else 0.
- RAS organisation: circular buffer with a top pointer and a count in 0..RAS_DEPTH.
- RAS push when full: overwrite the oldest entry, advance the top pointer, count stays RAS_DEPTH.
- RAS pop when empty: no change; ras_uflow pulses for 1 cycle (registered).
- Push and pop in the same cycle cannot occur because jr beats jmp. A jr_ret pop still uses jr_tgt, never ras_top; ras_top is advisory.
- jmp_link without jmp, and jr_ret without jr, have no effect.
- Latency: pc updates one cycle after a request is sampled. epc and badaddr update on the same edge as pc.

Test Plan:
- Reset then 3 idle cycles (ADDR_W=32) → pc = 0, 4, 8, 12; ras_empty = 1; exc_taken = 0.
- At pc=0x100: br_taken, br_off=16'hFFFE → pc=0xFC. Next, from pc=0xFC, jmp with jmp_tgt=26'h40 → pc=0x100.
- Wrap: at pc=0xFFFF_FFFC with no request → pc=0x0000_0000.
- At pc=0x200: jmp+jmp_link → ras_top=0x204, ras_empty=0. Later jr+jr_ret with jr_tgt=0x204 → pc=0x204, ras_empty=1. A second jr+jr_ret → ras_uflow pulses once, count stays 0.
- At pc=0x300: jr, jr_tgt=0x1002 → pc=0x180, epc=0x300, badaddr=0x1002, exc_taken=1 for exactly one cycle. Push 5 times with RAS_DEPTH=4 → count 4, ras_top = the last pushed value.
- At pc=0x40: stall+jmp → pc stays 0x40. stall+exc_req → pc=0x180, epc=0x40. rst asserted in the same cycle as exc_req → pc=RESET_VECTOR, epc=0.
